// File: rtl/prog_loader_if.sv
// Host-side bundle for the program loader: load control, write strobe/data,
// combinational program read port and load status.
interface prog_loader_if #(
  parameter int INSTR_WIDTH = 5,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
);
  logic                   load_start;
  logic                   load_end;
  logic                   wr_strobe;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   master_clear;
  logic                   load_active;
  logic [ADDR_WIDTH:0]    load_count;
  logic                   overflow_err;

  // Host / downstream core side.
  modport master (
    output load_start, load_end, wr_strobe, instr_in, rd_addr,
    input  rd_data, master_clear, load_active, load_count, overflow_err
  );

  // Loader side.
  modport slave (
    input  load_start, load_end, wr_strobe, instr_in, rd_addr,
    output rd_data, master_clear, load_active, load_count, overflow_err
  );
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader: captures instruction words, one per rising edge of a
// slow pad strobe, into a DEPTH-entry register file in address order, and
// raises master_clear once the program is complete (RAM full or host end).
module prog_loader #(
  parameter int INSTR_WIDTH = 5,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;

  logic                   sync1_r;
  logic                   sync2_r;
  logic                   prev_r;
  logic                   wp_s;

  logic [ADDR_WIDTH-1:0]  ptr_r;
  logic [ADDR_WIDTH:0]    count_r;
  logic                   master_clear_r;
  logic                   load_active_r;
  logic                   overflow_err_r;

  logic                   clr_s;
  logic                   wr_en_s;
  logic                   ovf_set_s;
  logic                   last_s;

  logic [INSTR_WIDTH-1:0] ram_r [DEPTH];

  // Two-flop synchroniser plus previous-sample flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= bus.wr_strobe;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // A held-high strobe produces a single one-cycle write pulse.
  assign wp_s   = sync2_r & ~prev_r;
  assign last_s = (ptr_r == ADDR_WIDTH'(DEPTH - 1));

  // Next-state and control decode; load_start outranks wp, wp outranks load_end.
  always_comb begin
    state_next_s = state_r;
    clr_s        = 1'b0;
    wr_en_s      = 1'b0;
    ovf_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.load_start) begin
          state_next_s = LOADING;
          clr_s        = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOADING: begin
        if (bus.load_start) begin
          state_next_s = LOADING;
          clr_s        = 1'b1;
        end else if (wp_s) begin
          wr_en_s = 1'b1;
          if (last_s || bus.load_end) begin
            state_next_s = DONE;
          end else begin
            state_next_s = LOADING;
          end
        end else if (bus.load_end) begin
          state_next_s = DONE;
        end else begin
          state_next_s = LOADING;
        end
      end
      DONE: begin
        if (bus.load_start) begin
          state_next_s = LOADING;
          clr_s        = 1'b1;
        end else if (wp_s) begin
          state_next_s = DONE;
          ovf_set_s    = 1'b1;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, pointer, count and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      ptr_r          <= {ADDR_WIDTH{1'b0}};
      count_r        <= {(ADDR_WIDTH+1){1'b0}};
      master_clear_r <= 1'b0;
      load_active_r  <= 1'b0;
      overflow_err_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (clr_s) begin
        ptr_r   <= {ADDR_WIDTH{1'b0}};
        count_r <= {(ADDR_WIDTH+1){1'b0}};
      end else if (wr_en_s) begin
        count_r <= count_r + (ADDR_WIDTH+1)'(1);
        // The pointer parks on the last word instead of wrapping.
        if (!last_s) begin
          ptr_r <= ptr_r + ADDR_WIDTH'(1);
        end
      end
      if (clr_s) begin
        overflow_err_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_err_r <= 1'b1;
      end
      master_clear_r <= (state_next_s == DONE);
      load_active_r  <= (state_next_s == LOADING);
    end
  end

  // Program register file; reset clears every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_r[i] <= {INSTR_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      ram_r[ptr_r] <= bus.instr_in;
    end
  end

  // Combinational read; addresses past the last word read as zero.
  generate
    if (DEPTH == (2 ** ADDR_WIDTH)) begin : g_rd_pow2
      assign bus.rd_data = ram_r[bus.rd_addr];
    end else begin : g_rd_npow2
      assign bus.rd_data = ({1'b0, bus.rd_addr} < (ADDR_WIDTH+1)'(DEPTH)) ?
                           ram_r[bus.rd_addr] : {INSTR_WIDTH{1'b0}};
    end
  endgenerate

  assign bus.master_clear = master_clear_r;
  assign bus.load_active  = load_active_r;
  assign bus.load_count   = count_r;
  assign bus.overflow_err = overflow_err_r;

endmodule
